// File: rtl/alu_seq.sv
// Multi-operation ALU with start/done handshake and persistent carry/zero/neg/ovf flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 9); otherwise opcode 9 is a NOP.
module alu_seq #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [DATA_BITS-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic                 neg,
  output logic                 ovf
);
  localparam int W   = DATA_BITS;
  localparam int MSB = W - 1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8;

  logic [W-1:0] result_q, result_d;
  logic         cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;

  // Single-cycle datapath
  logic [W-1:0] b_eff, res_n;
  logic [W:0]   sum;
  logic         cin, c_n, v_n, wr;

  always_comb begin
    b_eff = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    case (op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = cout_q;
    endcase
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    wr    = 1'b1;
    res_n = sum[W-1:0];
    c_n   = sum[W];
    v_n   = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: ;
      OP_AND: begin res_n = a & b; c_n = 1'b0; v_n = 1'b0; end
      OP_OR:  begin res_n = a | b; c_n = 1'b0; v_n = 1'b0; end
      OP_XOR: begin res_n = a ^ b; c_n = 1'b0; v_n = 1'b0; end
      OP_SHL: begin res_n = {a[W-2:0], 1'b0}; c_n = a[MSB]; v_n = 1'b0; end
      OP_SHR: begin res_n = {1'b0, a[W-1:1]}; c_n = a[0];   v_n = 1'b0; end
      default: begin wr = 1'b0; res_n = result_q; c_n = cout_q; v_n = ovf_q; end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(W + 1);
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [0:0] S_IDLE = 1'b0, S_MUL = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
  logic [W-1:0]   mplier_q, mplier_d;

  assign ready  = (state_q == S_IDLE);
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign ready = 1'b1;
`endif

  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (state_q == S_IDLE) begin
      if (start && op == OP_MUL) begin
        state_d  = S_MUL;
        cnt_d    = CW'(W);
        acc_d    = '0;
        mcand_d  = {{W{1'b0}}, a};
        mplier_d = b;
      end else if (start) begin
        done_d = 1'b1;
        if (wr) begin
          result_d = res_n;
          cout_d   = c_n;
          ovf_d    = v_n;
          zero_d   = (res_n == '0);
          neg_d    = res_n[MSB];
        end
      end
    end else begin
      // One multiplier bit per cycle; the last iteration writes the outputs directly.
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = acc_nx[W-1:0];
        cout_d   = |acc_nx[2*W-1:W];
        ovf_d    = 1'b0;
        zero_d   = (acc_nx[W-1:0] == '0);
        neg_d    = acc_nx[MSB];
      end
    end
`else
    if (start) begin
      done_d = 1'b1;
      if (wr) begin
        result_d = res_n;
        cout_d   = c_n;
        ovf_d    = v_n;
        zero_d   = (res_n == '0);
        neg_d    = res_n[MSB];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
endmodule
